discriminator_serial: RTL and testbench



---
 rtl/discriminator_serial.sv | 174 +++++++++++++++++
 tb/tb_discriminator_serial.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/discriminator_serial.sv
// Serial fixed-point discriminator: 9 -> 3 (ReLU) -> 1 network evaluated on one
// time-multiplexed MAC, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// L2    | hidden layer, one MAC per edge (n=0..2, i=0..8)
// L3    | output layer, one MAC per edge (n=0..2)
// DONE  | result held until out_ready
module discriminator_serial #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int N_PIXEL     = 9,
    parameter int N_NEURON_L2 = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_PIXEL*WIDTH-1:0]               x_in,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_PIXEL*N_NEURON_L2*WIDTH-1:0]   w_L2,
    input  logic [N_NEURON_L2*WIDTH-1:0]           b_L2,
    input  logic [N_NEURON_L2*WIDTH-1:0]           w_L3,
    input  logic [WIDTH-1:0]                       b_L3,
    output logic signed [WIDTH-1:0]                score,
    output logic                                   real_flag,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    localparam int ACC_W = 2*WIDTH + 4;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, L2, L3, DONE} state_t;

    state_t                   state;
    logic [3:0]               i_cnt;
    logic [1:0]               n_cnt;
    logic signed [WIDTH-1:0]  x_reg [N_PIXEL];
    logic signed [WIDTH-1:0]  h_reg [N_NEURON_L2];
    logic signed [ACC_W-1:0]  acc;

    logic signed [WIDTH-1:0]  w2_word [N_PIXEL*N_NEURON_L2];
    logic signed [WIDTH-1:0]  b2_word [N_NEURON_L2];
    logic signed [WIDTH-1:0]  w3_word [N_NEURON_L2];
    logic [4:0]               w_idx;

    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    logic signed [WIDTH-1:0]   bias;
    logic                      first_term;
    logic                      last_term;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_shift;
    logic signed [WIDTH-1:0]   sat_word;
    logic signed [WIDTH-1:0]   relu_word;

    assign in_ready = (state == IDLE);

    always_comb begin
        for (int k = 0; k < N_PIXEL*N_NEURON_L2; k++) begin
            w2_word[k] = w_L2[k*WIDTH +: WIDTH];
        end
        for (int k = 0; k < N_NEURON_L2; k++) begin
            b2_word[k] = b_L2[k*WIDTH +: WIDTH];
            w3_word[k] = w_L3[k*WIDTH +: WIDTH];
        end
    end

    assign w_idx = ({3'b000, n_cnt} * 5'd9) + {1'b0, i_cnt};

    always_comb begin
        mul_a      = '0;
        mul_b      = '0;
        bias       = '0;
        first_term = 1'b0;
        last_term  = 1'b0;
        case (state)
            L2: begin
                mul_a      = x_reg[i_cnt];
                mul_b      = w2_word[w_idx];
                bias       = b2_word[n_cnt];
                first_term = (i_cnt == 4'd0);
                last_term  = (i_cnt == 4'(N_PIXEL-1));
            end
            L3: begin
                mul_a      = h_reg[n_cnt];
                mul_b      = w3_word[n_cnt];
                bias       = b_L3;
                first_term = (n_cnt == 2'd0);
                last_term  = (n_cnt == 2'(N_NEURON_L2-1));
            end
            default: ;
        endcase
    end

    // The bias enters pre-scaled by FRAC so it lines up with the Q.2FRAC products.
    always_comb begin
        prod      = $signed({{WIDTH{mul_a[WIDTH-1]}}, mul_a}) * $signed({{WIDTH{mul_b[WIDTH-1]}}, mul_b});
        bias_ext  = $signed({{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias}) <<< FRAC;
        acc_sum   = (first_term ? bias_ext : acc) + $signed({{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod});
        acc_shift = acc_sum >>> FRAC;
        if (acc_shift > SAT_MAX) begin
            sat_word = SAT_MAX[WIDTH-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_word = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_word = acc_shift[WIDTH-1:0];
        end
        relu_word = sat_word[WIDTH-1] ? '0 : sat_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i_cnt     <= '0;
            n_cnt     <= '0;
            acc       <= '0;
            score     <= '0;
            real_flag <= 1'b0;
            out_valid <= 1'b0;
            for (int k = 0; k < N_PIXEL; k++) x_reg[k] <= '0;
            for (int k = 0; k < N_NEURON_L2; k++) h_reg[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < N_PIXEL; k++) x_reg[k] <= x_in[k*WIDTH +: WIDTH];
                        i_cnt <= '0;
                        n_cnt <= '0;
                        state <= L2;
                    end
                end
                L2: begin
                    acc <= acc_sum;
                    if (last_term) begin
                        h_reg[n_cnt] <= relu_word;
                        i_cnt        <= '0;
                        if (n_cnt == 2'(N_NEURON_L2-1)) begin
                            n_cnt <= '0;
                            state <= L3;
                        end else begin
                            n_cnt <= n_cnt + 2'd1;
                        end
                    end else begin
                        i_cnt <= i_cnt + 4'd1;
                    end
                end
                L3: begin
                    acc <= acc_sum;
                    if (last_term) begin
                        score     <= sat_word;
                        real_flag <= !sat_word[WIDTH-1] && (sat_word != '0);
                        out_valid <= 1'b1;
                        n_cnt     <= '0;
                        state     <= DONE;
                    end else begin
                        n_cnt <= n_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_discriminator_serial.sv
// Bench for discriminator_serial: directed samples checked against literals and
// against an arithmetic model of the network plus a cycle-level handshake model.
module tb_discriminator_serial;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [287:0]   x_in = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [863:0]   w_L2 = '0;
    logic [95:0]    b_L2 = '0;
    logic [95:0]    w_L3 = '0;
    logic [31:0]    b_L3 = '0;
    logic signed [31:0] score;
    logic           real_flag;
    logic           out_valid;
    logic           out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    discriminator_serial #(.WIDTH(32), .FRAC(16), .N_PIXEL(9), .N_NEURON_L2(3)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .w_L2(w_L2), .b_L2(b_L2), .w_L3(w_L3), .b_L3(b_L3),
        .score(score), .real_flag(real_flag), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic signed [31:0] clamp(input logic signed [71:0] v);
        if (v > 72'sd2147483647) return 32'sh7FFFFFFF;
        if (v < -72'sd2147483648) return 32'sh80000000;
        return v[31:0];
    endfunction

    // Real-number network in exact wide arithmetic: biases scaled by 2^16, floor on rescale.
    function automatic logic signed [31:0] model_score(input logic [287:0] x, input logic [863:0] w2,
                                                       input logic [95:0] b2, input logic [95:0] w3,
                                                       input logic [31:0] b3);
        logic signed [71:0] s;
        logic signed [31:0] h [3];
        logic signed [31:0] hc;
        for (int n = 0; n < 3; n++) begin
            s = $signed(b2[n*32 +: 32]) * 72'sd65536;
            for (int i = 0; i < 9; i++)
                s = s + $signed(x[i*32 +: 32]) * $signed(w2[(9*n+i)*32 +: 32]);
            hc = clamp(s >>> 16);
            h[n] = (hc < 0) ? 32'sd0 : hc;
        end
        s = $signed(b3) * 72'sd65536;
        for (int n = 0; n < 3; n++)
            s = s + h[n] * $signed(w3[n*32 +: 32]);
        return clamp(s >>> 16);
    endfunction

    // Cycle model: one sample in flight, result 30 edges after accept.
    logic signed [31:0] m_score = '0;
    logic signed [31:0] m_pending = '0;
    logic m_flag = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int   m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_score <= '0; m_flag <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy    <= 1'b1;
                m_cnt     <= 0;
                m_pending <= model_score(x_in, w_L2, b_L2, w_L3, b_L3);
            end
        end else if (!m_done) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 29) begin
                m_done  <= 1'b1;
                m_score <= m_pending;
                m_flag  <= (m_pending > 0);
            end
        end else if (out_ready) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
            check("mon_out_valid", {31'b0, out_valid}, {31'b0, m_done});
            check("mon_score", score, m_score);
            check("mon_real_flag", {31'b0, real_flag}, {31'b0, m_flag});
        end
    end

    task automatic cfg(input logic [31:0] xv, input logic [31:0] w2v, input logic [31:0] b2v,
                       input logic [31:0] w3v, input logic [31:0] b3v);
        for (int k = 0; k < 9; k++) x_in[k*32 +: 32] = xv;
        for (int k = 0; k < 27; k++) w_L2[k*32 +: 32] = w2v;
        for (int k = 0; k < 3; k++) begin
            b_L2[k*32 +: 32] = b2v;
            w_L3[k*32 +: 32] = w3v;
        end
        b_L3 = b3v;
    endtask

    task automatic accept_sample(input string name);
        int cnt;
        @(negedge clk);
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_accept"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_sample(input string name, input logic [31:0] exp_s, input logic exp_f,
                              input int hold, input bit poke);
        int cnt;
        accept_sample(name);
        out_ready = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (poke && cnt == 5) begin
                in_valid = 1'b1;
                for (int k = 0; k < 9; k++) x_in[k*32 +: 32] = 32'h0BAD0000;
            end
            if (poke && cnt == 7) in_valid = 1'b0;
        end while (!out_valid && cnt < 100);
        check({name, "_latency"}, cnt, 32'd30);
        check({name, "_score"}, score, exp_s);
        check({name, "_flag"}, {31'b0, real_flag}, {31'b0, exp_f});
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_score"}, score, exp_s);
            check({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check({name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({name, "_post_valid"}, {31'b0, out_valid}, 32'd0);
        check({name, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({name, "_post_score"}, score, exp_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_score", score, 32'h0);
        check("reset_flag", {31'b0, real_flag}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        mon_on = 1'b1;

        cfg(32'h12345678, 32'h0, 32'h00030000, 32'h0, 32'h00010000);
        run_sample("bias_only", 32'h00010000, 1'b1, 0, 1'b0);

        cfg(32'h00010000, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
        run_sample("dot", 32'h001B0000, 1'b1, 0, 1'b0);

        cfg(32'h00010000, 32'hFFFF0000, 32'h0, 32'h00010000, 32'hFFFF8000);
        run_sample("relu_neg", 32'hFFFF8000, 1'b0, 0, 1'b0);

        cfg(32'h00010000, 32'hFFFF0000, 32'h0, 32'h00010000, 32'h0);
        run_sample("relu_zero", 32'h00000000, 1'b0, 0, 1'b0);

        // h = 0.5 each, w3 = -1 lsb: -1.5 must floor to -2.
        cfg(32'h00010000, 32'h0, 32'h00008000, 32'hFFFFFFFF, 32'h0);
        run_sample("floor", 32'hFFFFFFFE, 1'b0, 0, 1'b0);

        cfg(32'h00010000, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
        run_sample("handshake", 32'h001B0000, 1'b1, 5, 1'b1);

        // h = 1 + 9*(2*0.5) = 10 each; 10 - 10 + 5 - 0.25 = 4.75.
        cfg(32'h00020000, 32'h00008000, 32'h00010000, 32'h00010000, 32'hFFFFC000);
        w_L3[32 +: 32] = 32'hFFFF0000;
        w_L3[64 +: 32] = 32'h00008000;
        run_sample("back2back", 32'h0004C000, 1'b1, 0, 1'b0);

        cfg(32'h7FFF0000, 32'h7FFF0000, 32'h0, 32'h00010000, 32'h0);
        run_sample("saturate", 32'h7FFFFFFF, 1'b1, 0, 1'b0);

        cfg(32'h00010000, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
        accept_sample("midreset");
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_score", score, 32'h0);
        check("midreset_flag", {31'b0, real_flag}, 32'd0);

        cfg(32'h00010000, 32'hFFFF0000, 32'h0, 32'h00010000, 32'hFFFF8000);
        run_sample("after_reset", 32'hFFFF8000, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
